// File: rtl/uart_apb_csr_bank.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_csr_bank
// Brief    : APB3 CSR bank for the UART-to-APB bridge: scratch RAM, CTRL,
//            STATUS mirror, W1C sticky interrupts, wait-state generator.
//            Define CSR_LOCK_EN to enable the write-once CTRL.LOCK bit.
// Revision : 1.0
// ============================================================================
module uart_apb_csr_bank #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 16,
    parameter int SCRATCH_DEPTH = 16,
    parameter int WAIT_STATES   = 0,
    parameter int LOC_W         = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    input  logic                ParErrPulse,
    input  logic [15:0]         ParErrCount,
    input  logic                ErrInjDone,
    input  logic [LOC_W-1:0]    tx_FifoEmptyLoc,
    input  logic [LOC_W-1:0]    rx_FifoEmptyLoc,
    output logic [1:0]          TxClk,
    output logic                ParEn,
    output logic                LoopBack,
    output logic                ParErrEn,
    output logic                ParErrclr,
    output logic                ErrInjEn,
    output logic                par_type,
    output logic [1:0]          ErrInjType,
    output logic                Irq
);

    localparam int                c_SIDX_W       = (SCRATCH_DEPTH > 1) ? $clog2(SCRATCH_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] c_SCRATCH_END  = ADDR_W'(4 * SCRATCH_DEPTH);
    localparam logic [ADDR_W-1:0] c_ADDR_CTRL    = ADDR_W'(32'hFFE0);
    localparam logic [ADDR_W-1:0] c_ADDR_STATUS  = ADDR_W'(32'hFFE4);
    localparam logic [ADDR_W-1:0] c_ADDR_INTSTAT = ADDR_W'(32'hFFE8);
    localparam logic [ADDR_W-1:0] c_ADDR_INTEN   = ADDR_W'(32'hFFEC);
    localparam logic [3:0]        c_WAIT_LOAD    = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [9:0]        c_CTRL_RST     = 10'h0B0;
    localparam logic [LOC_W-1:0]  c_TX_FULL      = {LOC_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_scratch [SCRATCH_DEPTH];
    logic [9:0]          r_ctrl;
    logic                r_parerrclr;
    logic [2:0]          r_int_stat;
    logic [2:0]          r_int_en;
    logic                r_irq;
    logic                r_errinj_d;
    logic                r_tx_full_d;

    logic                w_sel_scratch;
    logic                w_sel_ctrl;
    logic                w_sel_status;
    logic                w_sel_intstat;
    logic                w_sel_inten;
    logic                w_mapped;
    logic                w_break;
    logic                w_locked;
    logic                w_err;
    logic                w_done;
    logic                w_commit;
    logic [c_SIDX_W-1:0] w_sidx;
    logic [31:0]         w_status;
    logic [31:0]         w_ctrl_rd;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_tx_full;
    logic [2:0]          w_int_set;
    logic [2:0]          w_int_clr;

    // Decode uses the address captured in the setup phase.
    assign w_sel_scratch = (r_addr < c_SCRATCH_END);
    assign w_sel_ctrl    = (r_addr[ADDR_W-1:2] == c_ADDR_CTRL[ADDR_W-1:2]);
    assign w_sel_status  = (r_addr[ADDR_W-1:2] == c_ADDR_STATUS[ADDR_W-1:2]);
    assign w_sel_intstat = (r_addr[ADDR_W-1:2] == c_ADDR_INTSTAT[ADDR_W-1:2]);
    assign w_sel_inten   = (r_addr[ADDR_W-1:2] == c_ADDR_INTEN[ADDR_W-1:2]);
    assign w_mapped      = w_sel_scratch | w_sel_ctrl | w_sel_status | w_sel_intstat | w_sel_inten;
    assign w_sidx        = r_addr[c_SIDX_W+1:2];

    assign w_break = (r_state != IDLE) && (!PSEL || (PADDR != r_addr) || (PWRITE != r_write));

`ifdef CSR_LOCK_EN
    logic r_lock;
    assign w_locked  = r_lock;
    assign w_ctrl_rd = {21'd0, r_lock, r_ctrl};
`else
    assign w_locked  = 1'b0;
    assign w_ctrl_rd = {22'd0, r_ctrl};
`endif

    assign w_err = w_break || !w_mapped || (r_write && w_sel_status) ||
                   (w_locked && r_write && (w_sel_ctrl || w_sel_inten));

    assign w_done = ((r_state == ACCESS) && ((WAIT_STATES == 0) || w_break)) ||
                    ((r_state == WAIT) && ((r_cnt == 4'd0) || w_break));

    assign w_commit = w_done && r_write && !w_err;

    always_comb begin
        w_status                  = '0;
        w_status[15:0]            = ParErrCount;
        w_status[16 +: LOC_W]     = tx_FifoEmptyLoc;
        w_status[24 +: LOC_W]     = rx_FifoEmptyLoc;
        w_status[31]              = ErrInjDone;
    end

    always_comb begin
        w_rdata = '0;
        if (w_sel_scratch) begin
            w_rdata = r_scratch[w_sidx];
        end else if (w_sel_ctrl) begin
            w_rdata = DATA_W'(w_ctrl_rd);
        end else if (w_sel_status) begin
            w_rdata = DATA_W'(w_status);
        end else if (w_sel_intstat) begin
            w_rdata = DATA_W'(r_int_stat);
        end else if (w_sel_inten) begin
            w_rdata = DATA_W'(r_int_en);
        end
    end

    assign PREADY  = w_done;
    assign PSLVERR = w_done && w_err;
    assign PRDATA  = (w_done && !r_write && !w_err) ? w_rdata : '0;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (PSEL && !PENABLE) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = (w_break || (WAIT_STATES == 0)) ? IDLE : WAIT;
            WAIT:    if (w_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && PSEL && !PENABLE) begin
                r_addr  <= PADDR;
                r_write <= PWRITE;
            end
            if (r_state == ACCESS) begin
                r_cnt <= c_WAIT_LOAD;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < SCRATCH_DEPTH; i++) begin
                r_scratch[i] <= '0;
            end
        end else if (w_commit && w_sel_scratch) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (PSTRB[b]) r_scratch[w_sidx][8*b +: 8] <= PWDATA[8*b +: 8];
            end
        end
    end

    // CTRL bit 2 is never stored; it only launches the ParErrclr pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ctrl      <= c_CTRL_RST;
            r_parerrclr <= 1'b0;
            r_int_en    <= 3'd0;
        end else begin
            r_parerrclr <= w_commit && w_sel_ctrl && PSTRB[0] && PWDATA[2];
            if (w_commit && w_sel_ctrl) begin
                if (PSTRB[0]) r_ctrl[7:0] <= {PWDATA[7:3], 1'b0, PWDATA[1:0]};
                if (PSTRB[1]) r_ctrl[9:8] <= PWDATA[9:8];
            end
            if (w_commit && w_sel_inten && PSTRB[0]) begin
                r_int_en <= PWDATA[2:0];
            end
        end
    end

`ifdef CSR_LOCK_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_lock <= 1'b0;
        end else if (w_commit && w_sel_ctrl && PSTRB[1] && PWDATA[10]) begin
            r_lock <= 1'b1;
        end
    end
`endif

    assign w_tx_full = (tx_FifoEmptyLoc == c_TX_FULL);
    assign w_int_set = {w_tx_full && !r_tx_full_d, ErrInjDone && !r_errinj_d, ParErrPulse};
    assign w_int_clr = (w_commit && w_sel_intstat && PSTRB[0]) ? PWDATA[2:0] : 3'd0;

    // Set is OR-ed in after the clear so a coincident event wins.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_int_stat  <= 3'd0;
            r_irq       <= 1'b0;
            r_errinj_d  <= 1'b0;
            r_tx_full_d <= 1'b0;
        end else begin
            r_int_stat  <= (r_int_stat & ~w_int_clr) | w_int_set;
            r_irq       <= |(r_int_stat & r_int_en);
            r_errinj_d  <= ErrInjDone;
            r_tx_full_d <= w_tx_full;
        end
    end

    assign TxClk      = r_ctrl[7:6];
    assign ParEn      = r_ctrl[5];
    assign LoopBack   = r_ctrl[4];
    assign ParErrEn   = r_ctrl[3];
    assign ErrInjEn   = r_ctrl[1];
    assign par_type   = r_ctrl[0];
    assign ErrInjType = r_ctrl[9:8];
    assign ParErrclr  = r_parerrclr;
    assign Irq        = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_csr_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_apb_csr_bank
// Brief    : Directed plus randomized bench for uart_apb_csr_bank against a
//            cycle-level reference model (WAIT_STATES = 2).
// Revision : 1.0
// ============================================================================
module tb_uart_apb_csr_bank;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 16;
    localparam int WS     = 2;
    localparam int LOC_W  = 4;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [15:0]       PADDR = '0;
    logic [31:0]       PWDATA = '0;
    logic [3:0]        PSTRB = '0;
    logic [31:0]       PRDATA;
    logic              PREADY, PSLVERR;
    logic              ParErrPulse = 1'b0;
    logic [15:0]       ParErrCount = '0;
    logic              ErrInjDone = 1'b0;
    logic [3:0]        tx_loc = '0, rx_loc = '0;
    logic [1:0]        TxClk, ErrInjType;
    logic              ParEn, LoopBack, ParErrEn, ParErrclr, ErrInjEn, par_type, Irq;

    always #5 CLK = ~CLK;

    uart_apb_csr_bank #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SCRATCH_DEPTH(DEPTH),
        .WAIT_STATES(WS), .LOC_W(LOC_W)
    ) dut (
        .CLK(CLK), .RST(RST),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .ParErrPulse(ParErrPulse), .ParErrCount(ParErrCount),
        .ErrInjDone(ErrInjDone), .tx_FifoEmptyLoc(tx_loc), .rx_FifoEmptyLoc(rx_loc),
        .TxClk(TxClk), .ParEn(ParEn), .LoopBack(LoopBack), .ParErrEn(ParErrEn),
        .ParErrclr(ParErrclr), .ErrInjEn(ErrInjEn), .par_type(par_type),
        .ErrInjType(ErrInjType), .Irq(Irq)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_scratch [DEPTH];
    logic [9:0]  m_ctrl;
    logic        m_lock;
    logic [2:0]  m_int_stat, m_int_en;
    logic        m_irq, m_pclr, m_txfull_d, m_errinj_d;
    logic        p_valid = 1'b0;
    logic [15:0] p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_strb;
    bit          bg_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wa(input logic [15:0] a);
        return {a[15:2], 2'b00};
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        if (a < 16'(4 * DEPTH)) return m_scratch[a[5:2]];
        case (wa(a))
            16'hFFE0: return {21'd0, m_lock, m_ctrl};
            16'hFFE4: return {ErrInjDone, 3'd0, rx_loc, 4'd0, tx_loc, ParErrCount};
            16'hFFE8: return {29'd0, m_int_stat};
            16'hFFEC: return {29'd0, m_int_en};
            default:  return 32'd0;
        endcase
    endfunction

    function automatic bit m_err(input logic [15:0] a, input bit w);
        bit mapped;
        mapped = (a < 16'(4 * DEPTH)) || (wa(a) >= 16'hFFE0 && wa(a) <= 16'hFFEC);
        return !mapped || (w && wa(a) == 16'hFFE4) ||
               (m_lock && w && (wa(a) == 16'hFFE0 || wa(a) == 16'hFFEC));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) m_scratch[i] = '0;
        m_ctrl = 10'h0B0; m_lock = 1'b0; m_int_stat = '0; m_int_en = '0;
        m_irq = 1'b0; m_pclr = 1'b0; m_txfull_d = 1'b0; m_errinj_d = 1'b0; p_valid = 1'b0;
    endtask

    // One clock of the model followed by per-cycle output checks at negedge+1.
    task automatic step();
        logic [2:0] set_v, clr_v;
        logic       tf, nxt_pclr, nxt_irq;
        tf       = (tx_loc == 4'hF);
        set_v    = {tf && !m_txfull_d, ErrInjDone && !m_errinj_d, ParErrPulse};
        clr_v    = 3'd0;
        nxt_pclr = 1'b0;
        nxt_irq  = |(m_int_stat & m_int_en);
        if (p_valid) begin
            if (p_addr < 16'(4 * DEPTH)) begin
                for (int b = 0; b < 4; b++)
                    if (p_strb[b]) m_scratch[p_addr[5:2]][8*b +: 8] = p_data[8*b +: 8];
            end else if (wa(p_addr) == 16'hFFE0) begin
                if (p_strb[0]) begin
                    m_ctrl[7:0] = p_data[7:0] & 8'hFB;
                    nxt_pclr    = p_data[2];
                end
                if (p_strb[1]) m_ctrl[9:8] = p_data[9:8];
`ifdef CSR_LOCK_EN
                if (p_strb[1] && p_data[10]) m_lock = 1'b1;
`endif
            end else if (wa(p_addr) == 16'hFFE8) begin
                if (p_strb[0]) clr_v = p_data[2:0];
            end else if (wa(p_addr) == 16'hFFEC) begin
                if (p_strb[0]) m_int_en = p_data[2:0];
            end
        end
        m_int_stat = (m_int_stat & ~clr_v) | set_v;
        m_irq      = nxt_irq;
        m_pclr     = nxt_pclr;
        m_txfull_d = tf;
        m_errinj_d = ErrInjDone;
        p_valid    = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        if (bg_en) begin
            ParErrPulse = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) ErrInjDone = ~ErrInjDone;
            tx_loc      = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            rx_loc      = 4'($urandom);
            ParErrCount = 16'($urandom);
        end else begin
            ParErrPulse = 1'b0;
        end
        #1;
        chk("irq", 32'(Irq), 32'(m_irq));
        chk("parerrclr", 32'(ParErrclr), 32'(m_pclr));
        chk("ctrl_outs", 32'({ErrInjType, TxClk, ParEn, LoopBack, ParErrEn, ErrInjEn, par_type}),
            32'({m_ctrl[9:3], m_ctrl[1:0]}));
    endtask

    task automatic apb(input logic [15:0] a, input bit w, input logic [31:0] d,
                       input logic [3:0] s, input bit pulse_at_done,
                       output logic [31:0] rd, output logic err);
        bit done;
        bit exp_err;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d; PSTRB = s;
        step();
        PENABLE = 1'b1;
        #1;
        done = 1'b0; rd = '0; err = 1'b0;
        for (int cyc = 1; cyc <= WS + 4 && !done; cyc++) begin
            if (PREADY === 1'b1) begin
                chk("ready_cycle", 32'(cyc), 32'(WS + 1));
                exp_err = m_err(a, w);
                chk("pslverr", 32'(PSLVERR), 32'(exp_err));
                if (!w && !exp_err) chk("prdata", PRDATA, m_read(a));
                rd = PRDATA; err = PSLVERR; done = 1'b1;
                if (w && !exp_err) begin
                    p_valid = 1'b1; p_addr = a; p_data = d; p_strb = s;
                end
                if (pulse_at_done) ParErrPulse = 1'b1;
            end else begin
                chk("prdata_not_ready", PRDATA, 32'd0);
            end
            step();
        end
        chk("ready_seen", 32'(done), 32'd1);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic do_reset();
        bg_en = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; ParErrPulse = 1'b0;
        ErrInjDone = 1'b0; tx_loc = '0; rx_loc = '0; ParErrCount = '0;
        RST = 1'b0;
        m_reset();
        #12;
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_txclk", 32'(TxClk), 32'd2);
        chk("rst_paren_lb", 32'({ParEn, LoopBack}), 32'd3);
        chk("rst_irq", 32'(Irq), 32'd0);
        chk("rst_other", 32'({ParErrEn, ParErrclr, ErrInjEn, par_type, ErrInjType}), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [15:0] a;
        int          sel;

        do_reset();
        apb(16'hFFE0, 1'b0, 32'd0, 4'h0, 1'b0, rd, er);
        chk("ctrl_reset_read", rd, 32'h0000_00B0);

        apb(16'h0004, 1'b1, 32'hA5A5_A5A5, 4'b0101, 1'b0, rd, er);
        apb(16'h0004, 1'b0, 32'd0, 4'h0, 1'b0, rd, er);
        chk("strobe_read", rd, 32'h00A5_00A5);

        apb(16'hFFE0, 1'b1, 32'h0000_0204, 4'hF, 1'b0, rd, er);
        chk("pclr_high", 32'(ParErrclr), 32'd1);
        chk("errinjtype", 32'(ErrInjType), 32'd2);
        step();
        chk("pclr_low", 32'(ParErrclr), 32'd0);
        apb(16'hFFE0, 1'b0, 32'd0, 4'h0, 1'b0, rd, er);
        chk("ctrl_readback", rd, 32'h0000_0200);

        apb(16'hFFEC, 1'b1, 32'h1, 4'hF, 1'b0, rd, er);
        ParErrPulse = 1'b1;
        step();
        chk("irq_lag", 32'(Irq), 32'd0);
        step();
        chk("irq_set", 32'(Irq), 32'd1);
        apb(16'hFFE8, 1'b0, 32'd0, 4'h0, 1'b0, rd, er);
        chk("intstat_set", rd, 32'h1);
        apb(16'hFFE8, 1'b1, 32'h1, 4'h1, 1'b1, rd, er);
        apb(16'hFFE8, 1'b0, 32'd0, 4'h0, 1'b0, rd, er);
        chk("set_wins", rd, 32'h1);
        apb(16'hFFE8, 1'b1, 32'h1, 4'h1, 1'b0, rd, er);
        apb(16'hFFE8, 1'b0, 32'd0, 4'h0, 1'b0, rd, er);
        chk("w1c_clear", rd, 32'h0);

        ParErrCount = 16'h1234; tx_loc = 4'h3; rx_loc = 4'h5; ErrInjDone = 1'b0;
        apb(16'hFFF0, 1'b0, 32'd0, 4'h0, 1'b0, rd, er);
        chk("unmapped_err", 32'(er), 32'd1);
        apb(16'hFFE4, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, er);
        chk("status_wr_err", 32'(er), 32'd1);
        apb(16'hFFE4, 1'b0, 32'd0, 4'h0, 1'b0, rd, er);
        chk("status_value", rd, 32'h0503_1234);

        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h0010; PWRITE = 1'b1;
        PWDATA = 32'hCAFE_F00D; PSTRB = 4'hF;
        step();
        PENABLE = 1'b1; PADDR = 16'h0014;
        #1;
        chk("break_ready", 32'(PREADY), 32'd1);
        chk("break_slverr", 32'(PSLVERR), 32'd1);
        step();
        PSEL = 1'b0; PENABLE = 1'b0;
        apb(16'h0010, 1'b0, 32'd0, 4'h0, 1'b0, rd, er);
        chk("break_no_write", rd, 32'd0);

`ifdef CSR_LOCK_EN
        do_reset();
        apb(16'hFFE0, 1'b1, 32'h0000_0400, 4'hF, 1'b0, rd, er);
        chk("lock_set_ok", 32'(er), 32'd0);
        apb(16'hFFE0, 1'b1, 32'h0000_0000, 4'hF, 1'b0, rd, er);
        chk("lock_wr_err", 32'(er), 32'd1);
        apb(16'hFFE0, 1'b0, 32'd0, 4'h0, 1'b0, rd, er);
        chk("lock_ctrl_kept", rd, 32'h0000_0400);
        apb(16'hFFEC, 1'b1, 32'h7, 4'hF, 1'b0, rd, er);
        chk("lock_inten_err", 32'(er), 32'd1);
        do_reset();
        apb(16'hFFE0, 1'b0, 32'd0, 4'h0, 1'b0, rd, er);
        chk("lock_reset_ctrl", rd, 32'h0000_00B0);
`endif

        bg_en = 1'b1;
        for (int n = 0; n < 250; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3: a = 16'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
                4:          a = 16'hFFE0;
                5:          a = 16'hFFE4;
                6:          a = 16'hFFE8;
                7:          a = 16'hFFEC;
                8:          a = 16'hFFF0 + 16'($urandom_range(0, 15));
                default:    a = 16'($urandom_range(16'h0040, 16'hFFDF));
            endcase
            apb(a, 1'($urandom), $urandom, 4'($urandom), 1'b0, rd, er);
            repeat ($urandom_range(0, 2)) step();
        end
        bg_en = 1'b0;

        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h0008; PWRITE = 1'b1;
        PWDATA = 32'hDEAD_BEEF; PSTRB = 4'hF;
        step();
        PENABLE = 1'b1;
        step();
        step();
        chk("mid_ready", 32'(PREADY), 32'd1);
        RST = 1'b0;
        #1;
        chk("rst_drop_ready", 32'(PREADY), 32'd0);
        do_reset();
        apb(16'h0008, 1'b0, 32'd0, 4'h0, 1'b0, rd, er);
        chk("write_lost", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
